// File: rtl/dzcpu_trace_monitor.sv
// dzcpu_trace_monitor: execution-trace capture and stop-condition monitor.
// Captures one retire record per iEof in RUN into a circular buffer, and
// stops on PC breakpoints or a cycle-limit timeout.
// Optional: define TRACE_MEMWATCH_EN to also capture MMU write records.
module dzcpu_trace_monitor #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned NUM_BP  = 2,
  parameter logic [31:0] TIMEOUT = 32'd5000000
) (
  input  logic                     iClock,
  input  logic                     iReset,
  input  logic                     iEof,
  input  logic [15:0]              iPc,
  input  logic [15:0]              iSp,
  input  logic [63:0]              iRegs,
  input  logic                     iMemWe,
  input  logic [15:0]              iMemAddr,
  input  logic [7:0]               iMemData,
  input  logic [16*NUM_BP-1:0]     iBpAddr,
  input  logic [NUM_BP-1:0]        iBpEn,
  input  logic                     iArm,
  input  logic                     iRdEn,
  output logic [97:0]              oRdData,
  output logic                     oEmpty,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic                     oOverflow,
  output logic                     oStop,
  output logic [NUM_BP-1:0]        oBpHit,
  output logic                     oTimeout,
  output logic [31:0]              oCycles
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] TO_LAST = TIMEOUT - 32'd1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_t;

  state_t              state_q, state_d;
  logic [97:0]         mem_q [DEPTH];
  logic [AW-1:0]       rd_q, rd_d, wr_q, wr_d, wr1;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic [NUM_BP-1:0]   bp_q, bp_d, bp_match;
  logic                to_q, to_d;
  logic [31:0]         cyc_q, cyc_d;
  logic                run;
  logic                mem_we;
  logic [97:0]         mem_rec;
  logic [97:0]         push_rec0, push_rec1;
  logic [1:0]          push_vld;

`ifdef TRACE_MEMWATCH_EN
  assign mem_we  = iMemWe;
  assign mem_rec = {2'b10, 72'b0, iMemAddr, iMemData};
`else
  logic unused_mem;
  assign unused_mem = ^{iMemWe, iMemAddr, iMemData};
  assign mem_we  = 1'b0;
  assign mem_rec = '0;
`endif

  assign run = (state_q == ST_RUN) && !iArm;
  assign wr1 = wr_q + 1'b1;

  // Build up to two records per cycle: the retire record always goes first.
  always_comb begin
    push_vld  = '0;
    push_rec0 = '0;
    push_rec1 = mem_rec;
    if (run) begin
      push_vld[0] = iEof | mem_we;
      push_vld[1] = iEof & mem_we;
      push_rec0   = iEof ? {2'b01, iPc, iSp, iRegs} : mem_rec;
    end
  end

  // Buffer bookkeeping: a pop is applied before pushes, so push+pop when full does not overflow.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (iArm) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (iRdEn && (cnt_q != '0)) begin
        rd_d  = rd_q + 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
      for (int unsigned i = 0; i < 2; i++) begin
        if (push_vld[i]) begin
          if (cnt_d == CW'(DEPTH)) begin
            rd_d  = rd_d + 1'b1;
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_d + 1'b1;
          end
          wr_d = wr_d + 1'b1;
        end
      end
    end
  end

  // Lowest enabled matching breakpoint channel, one-hot.
  always_comb begin
    logic found;
    found    = 1'b0;
    bp_match = '0;
    for (int unsigned k = 0; k < NUM_BP; k++) begin
      if (!found && iBpEn[k] && (iPc == iBpAddr[16*k +: 16])) begin
        bp_match[k] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  // Run-control FSM: arm, cycle counting, breakpoint and timeout stop.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bp_d    = bp_q;
    to_d    = to_q;
    if (iArm) begin
      state_d = ST_RUN;
      cyc_d   = '0;
      bp_d    = '0;
      to_d    = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (cyc_q != '1) cyc_d = cyc_q + 32'd1;
      if (iEof && (bp_match != '0)) begin
        bp_d    = bp_match;
        state_d = ST_STOP;
      end else if ((TIMEOUT != 32'd0) && (cyc_q == TO_LAST)) begin
        to_d    = 1'b1;
        state_d = ST_STOP;
      end
    end
  end

  // State and control registers.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      bp_q    <= '0;
      to_q    <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      bp_q    <= bp_d;
      to_q    <= to_d;
      cyc_q   <= cyc_d;
    end
  end

  // Trace storage; contents are only meaningful up to the held count.
  always_ff @(posedge iClock) begin
    if (push_vld[0]) mem_q[wr_q] <= push_rec0;
    if (push_vld[1]) mem_q[wr1]  <= push_rec1;
  end

  assign oEmpty    = (cnt_q == '0);
  assign oCount    = cnt_q;
  assign oRdData   = oEmpty ? '0 : mem_q[rd_q];
  assign oOverflow = ovf_q;
  assign oStop     = (state_q == ST_STOP);
  assign oBpHit    = bp_q;
  assign oTimeout  = to_q;
  assign oCycles   = cyc_q;

endmodule

// File: tb/tb_dzcpu_trace_monitor.sv
// Self-checking bench for dzcpu_trace_monitor against a queue-based model.
module tb_dzcpu_trace_monitor;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned NUM_BP  = 2;
  localparam logic [31:0] TIMEOUT = 32'd100;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 eof, memwe, arm, rden;
  logic [15:0]          pc, sp, maddr;
  logic [63:0]          regs;
  logic [7:0]           mdata;
  logic [16*NUM_BP-1:0] bpaddr;
  logic [NUM_BP-1:0]    bpen;
  logic [97:0]          rdata;
  logic                 empty, ovf, stop, tout;
  logic [CW-1:0]        count;
  logic [NUM_BP-1:0]    bphit;
  logic [31:0]          cycles;

  dzcpu_trace_monitor #(.DEPTH(DEPTH), .NUM_BP(NUM_BP), .TIMEOUT(TIMEOUT)) dut (
    .iClock(clk), .iReset(rst), .iEof(eof), .iPc(pc), .iSp(sp), .iRegs(regs),
    .iMemWe(memwe), .iMemAddr(maddr), .iMemData(mdata), .iBpAddr(bpaddr),
    .iBpEn(bpen), .iArm(arm), .iRdEn(rden), .oRdData(rdata), .oEmpty(empty),
    .oCount(count), .oOverflow(ovf), .oStop(stop), .oBpHit(bphit),
    .oTimeout(tout), .oCycles(cycles)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: 0 idle, 1 run, 2 stop
  logic [97:0]       mq [$];
  int                mst;
  logic              movf, mto;
  logic [NUM_BP-1:0] mbp;
  logic [31:0]       mcyc;

  task automatic chk(input string name, input logic [97:0] act, input logic [97:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    mst  = 0;
    movf = 1'b0;
    mto  = 1'b0;
    mbp  = '0;
    mcyc = '0;
  endfunction

  function automatic void model_update();
    logic [97:0] recs [$];
    int hit;
    if (arm) begin
      mq.delete();
      movf = 1'b0; mbp = '0; mto = 1'b0; mcyc = '0; mst = 1;
      return;
    end
    if (rden && mq.size() > 0) void'(mq.pop_front());
    if (mst != 1) return;
    if (eof) recs.push_back({2'b01, pc, sp, regs});
`ifdef TRACE_MEMWATCH_EN
    if (memwe) recs.push_back({2'b10, 72'b0, maddr, mdata});
`endif
    foreach (recs[i]) begin
      if (mq.size() == DEPTH) begin
        void'(mq.pop_front());
        movf = 1'b1;
      end
      mq.push_back(recs[i]);
    end
    hit = -1;
    for (int k = 0; k < NUM_BP; k++)
      if (hit < 0 && eof && bpen[k] && pc == bpaddr[16*k +: 16]) hit = k;
    if (hit >= 0) begin
      mbp = '0;
      mbp[hit] = 1'b1;
      mst = 2;
    end else if (TIMEOUT != 0 && mcyc == TIMEOUT - 1) begin
      mto = 1'b1;
      mst = 2;
    end
    if (mcyc != 32'hFFFF_FFFF) mcyc = mcyc + 1;
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("empty",    98'(empty),  98'(mq.size() == 0));
      chk("count",    98'(count),  98'(mq.size()));
      chk("rddata",   rdata,       (mq.size() > 0) ? mq[0] : 98'd0);
      chk("overflow", 98'(ovf),    98'(movf));
      chk("stop",     98'(stop),   98'(mst == 2));
      chk("bphit",    98'(bphit),  98'(mbp));
      chk("timeout",  98'(tout),   98'(mto));
      chk("cycles",   98'(cycles), 98'(mcyc));
    end
  end

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_in();
    eof = 1'b0; memwe = 1'b0; arm = 1'b0; rden = 1'b0;
  endtask

  task automatic do_arm();
    idle_in();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic push_pc(input logic [15:0] p);
    eof = 1'b1; pc = p;
    sp = 16'hFFFE; regs = {$urandom, $urandom};
    step();
    eof = 1'b0;
  endtask

  initial begin
    logic [97:0] r;
    rst = 1'b1;
    idle_in();
    pc = '0; sp = '0; regs = '0; maddr = '0; mdata = '0;
    bpaddr = '0; bpen = '0;
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", 98'(empty), 98'd1);
    chk("rst_count", 98'(count), 98'd0);
    chk("rst_rddata", rdata, 98'd0);
    rst = 1'b0;

    // Basic capture and in-order pops
    do_arm();
    push_pc(16'h0000);
    push_pc(16'h0003);
    push_pc(16'h0006);
    chk("d1_count", 98'(count), 98'd3);
    r = rdata;
    chk("d1_pc0", 98'(r[95:80]), 98'h0000);
    chk("d1_tag", 98'(r[97:96]), 98'd1);
    for (int i = 0; i < 3; i++) begin
      r = rdata;
      chk("d1_popc", 98'(r[95:80]), 98'(3 * i));
      rden = 1'b1;
      step();
      rden = 1'b0;
    end
    chk("d1_empty", 98'(empty), 98'd1);

    // Overflow and push+pop when full
    do_arm();
    for (int i = 0; i < 20; i++) push_pc(16'(i));
    r = rdata;
    chk("d2_count", 98'(count), 98'd16);
    chk("d2_ovf", 98'(ovf), 98'd1);
    chk("d2_head", 98'(r[95:80]), 98'd4);
    eof = 1'b1; pc = 16'h0077; rden = 1'b1;
    step();
    idle_in();
    r = rdata;
    chk("d2_pp_count", 98'(count), 98'd16);
    chk("d2_pp_head", 98'(r[95:80]), 98'd5);
    rden = 1'b1;
    repeat (15) step();
    rden = 1'b0;
    r = rdata;
    chk("d2_last", 98'(r[95:80]), 98'h0077);
    chk("d2_last_cnt", 98'(count), 98'd1);

    // Breakpoint
    bpaddr = {16'h0000, 16'h003E}; bpen = 2'b01;
    do_arm();
    push_pc(16'h0010);
    push_pc(16'h003E);
    chk("d3_stop", 98'(stop), 98'd1);
    chk("d3_bphit", 98'(bphit), 98'b01);
    chk("d3_count", 98'(count), 98'd2);
    push_pc(16'h0020);
    chk("d3_nocap", 98'(count), 98'd2);
    bpen = '0;

    // Timeout
    do_arm();
    repeat (99) step();
    chk("d4_pre_stop", 98'(stop), 98'd0);
    chk("d4_pre_cyc", 98'(cycles), 98'd99);
    step();
    chk("d4_stop", 98'(stop), 98'd1);
    chk("d4_to", 98'(tout), 98'd1);
    chk("d4_cyc", 98'(cycles), 98'd100);
    repeat (3) step();
    chk("d4_hold", 98'(cycles), 98'd100);
    do_arm();
    chk("d4_arm_stop", 98'(stop), 98'd0);
    chk("d4_arm_to", 98'(tout), 98'd0);
    chk("d4_arm_cyc", 98'(cycles), 98'd0);

    // Breakpoint in the timeout cycle, both channels matching
    bpaddr = {16'h0150, 16'h0150}; bpen = 2'b11;
    do_arm();
    repeat (99) step();
    push_pc(16'h0150);
    chk("d5_bphit", 98'(bphit), 98'b01);
    chk("d5_to", 98'(tout), 98'd0);
    chk("d5_stop", 98'(stop), 98'd1);
    bpen = '0;

    // Simultaneous retire and memory write
    do_arm();
    eof = 1'b1; pc = 16'h0100; memwe = 1'b1; maddr = 16'h9FFF; mdata = 8'h00;
    step();
    idle_in();
`ifdef TRACE_MEMWATCH_EN
    chk("d6_count", 98'(count), 98'd2);
`else
    chk("d6_count", 98'(count), 98'd1);
`endif
    r = rdata;
    chk("d6_tag0", 98'(r[97:96]), 98'd1);
    chk("d6_pc", 98'(r[95:80]), 98'h0100);
    rden = 1'b1;
    step();
    rden = 1'b0;
`ifdef TRACE_MEMWATCH_EN
    r = rdata;
    chk("d6_tag1", 98'(r[97:96]), 98'd2);
    chk("d6_wr", 98'(r[23:0]), 98'h9FFF00);
`else
    chk("d6_empty", 98'(empty), 98'd1);
`endif

    // Randomized run with occasional re-arm and one asynchronous reset
    do_arm();
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) begin
        bpaddr = {16'($urandom_range(0, 63)), 16'($urandom_range(0, 63))};
        bpen   = 2'($urandom_range(0, 3));
      end
      if (i == 1500) begin
        #2;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
      eof   = ($urandom_range(0, 9) < 6);
      memwe = ($urandom_range(0, 9) < 3);
      rden  = ($urandom_range(0, 9) < 4);
      arm   = ($urandom_range(0, 59) == 0);
      pc    = 16'($urandom_range(0, 63));
      sp    = 16'($urandom);
      regs  = {$urandom, $urandom};
      maddr = 16'($urandom);
      mdata = 8'($urandom);
      step();
    end
    idle_in();
    step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
